// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Definitions shared by the pipeline stage register and its helpers.
//   - NOP_INST : canonical bubble instruction (addi x0,x0,0).
//   - pipe_state_e : occupancy state of a two-entry skid stage.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // EMPTY: no valid entry
    // BUSY : main entry valid, skid entry free
    // FULL : main and skid entries both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
//   Saturating event counter. Counts one per cycle with inc high, sticks at
//   all-ones, and is cleared only by rst.
//
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high clear
//     inc  in   count this cycle
//     cnt  out  W-bit count
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline stage register with valid/ready handshake and a two-entry skid
//   buffer. in_ready is a pure function of registered state, so there is no
//   combinational path from out_ready back to in_ready. When the stage is
//   empty or flushed the outputs carry a bubble (BUBBLE_INST, pc 0).
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     When defined, adds saturating stall_cnt / flush_cnt outputs.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset (beats flush and handshakes)
//     flush      in   drop all stage contents; input this cycle is discarded
//     in_valid   in   upstream entry valid
//     in_ready   out  stage can accept (registered, low only when FULL)
//     in_inst    in   upstream instruction
//     in_pc      in   upstream pc
//     out_valid  out  main entry valid
//     out_ready  in   downstream accepts
//     out_inst   out  main entry instruction
//     out_pc     out  main entry pc
//     stall_cnt  out  cycles with out_valid && !out_ready  (macro only)
//     flush_cnt  out  cycles with flush asserted           (macro only)
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                XLEN        = 64,
    parameter int                INST_W      = 32,
    parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(NOP_INST),
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [XLEN-1:0]   in_pc,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_state_e state_q, state_d;

    // Entry valid bits are implied by the state: main valid in BUSY/FULL,
    // skid valid in FULL only.
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [XLEN-1:0]   main_pc_q,   main_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [XLEN-1:0]   skid_pc_q,   skid_pc_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid  && in_ready;
    assign out_fire = out_valid && out_ready;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = BUSY;
                end
                BUSY: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                FULL: begin
                    if (out_fire) state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // -------------------------------------------------------------- output comb
    // Both flags come straight from the state register.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
    end

    // ------------------------------------------------------------ datapath comb
    always_comb begin
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            main_inst_d = BUBBLE_INST;
            main_pc_d   = '0;
            skid_inst_d = BUBBLE_INST;
            skid_pc_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_inst_d = in_inst;
                        main_pc_d   = in_pc;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_inst_d = in_inst;
                        main_pc_d   = in_pc;
                    end else if (in_fire) begin
                        // downstream stalled: park the new entry behind main
                        skid_inst_d = in_inst;
                        skid_pc_d   = in_pc;
                    end else if (out_fire) begin
                        main_inst_d = BUBBLE_INST;
                        main_pc_d   = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path applies
                    if (out_fire) begin
                        main_inst_d = skid_inst_q;
                        main_pc_d   = skid_pc_q;
                        skid_inst_d = BUBBLE_INST;
                        skid_pc_d   = '0;
                    end
                end
                default: begin
                    main_inst_d = BUBBLE_INST;
                    main_pc_d   = '0;
                    skid_inst_d = BUBBLE_INST;
                    skid_pc_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------- datapath reg
    always_ff @(posedge clk) begin
        if (rst) begin
            main_inst_q <= BUBBLE_INST;
            main_pc_q   <= '0;
            skid_inst_q <= BUBBLE_INST;
            skid_pc_q   <= '0;
        end else begin
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign out_inst = main_inst_q;
    assign out_pc   = main_pc_q;

`ifdef PIPE_PERF_CNT_EN
    // ---------------------------------------------------------- perf counters
    logic stall_inc;
    assign stall_inc = out_valid && !out_ready;

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .cnt (flush_cnt)
    );
`else
    // Counter logic and ports are not built; CNT_W is kept so the parameter
    // list is the same in both configurations.
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Directed vector table, counter sequence (PIPE_PERF_CNT_EN builds) and a
//   randomized run against a two-deep FIFO reference model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 32;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [XLEN-1:0]   out_pc;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_skid_reg #(
        .XLEN   (XLEN),
        .INST_W (INST_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] inst;
        logic [63:0] pc;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
        logic        e_ir;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    localparam int NVEC = 26;
    vec_t vt [NVEC];
    ent_t mq [$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] inst,
                                logic [63:0] pc, logic ordy, logic e_ov,
                                logic [31:0] e_inst, logic [63:0] e_pc, logic e_ir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.inst = inst; v.pc = pc; v.ordy = ordy;
        v.e_ov = e_ov; v.e_inst = e_inst; v.e_pc = e_pc; v.e_ir = e_ir;
        return v;
    endfunction

    // Inputs are changed 1 time unit after a rising edge; outputs are sampled
    // at the same offset after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(string name, logic e_ov, logic [31:0] e_inst,
                              logic [63:0] e_pc, logic e_ir);
        checks++;
        if (out_valid !== e_ov || out_inst !== e_inst || out_pc !== e_pc || in_ready !== e_ir) begin
            errors++;
            $display("FAIL %s: got ov=%0b inst=%h pc=%h ir=%0b, expected ov=%0b inst=%h pc=%h ir=%0b",
                     name, out_valid, out_inst, out_pc, in_ready, e_ov, e_inst, e_pc, e_ir);
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic check_cnt(string name, logic [CNT_W-1:0] got, logic [CNT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // r  f  iv inst     pc          or  | ov inst      pc         ir
        vt[0]  = mk(1, 0, 0, 32'h0,  64'h0,    0,  0, NOP,   64'h0,    1);
        vt[1]  = mk(1, 0, 0, 32'h0,  64'h0,    0,  0, NOP,   64'h0,    1);
        // streaming, one-cycle latency, in_ready stays high
        vt[2]  = mk(0, 0, 1, 32'hA,  64'h1000, 1,  1, 32'hA, 64'h1000, 1);
        vt[3]  = mk(0, 0, 1, 32'hB,  64'h1004, 1,  1, 32'hB, 64'h1004, 1);
        vt[4]  = mk(0, 0, 1, 32'hC,  64'h1008, 1,  1, 32'hC, 64'h1008, 1);
        vt[5]  = mk(0, 0, 1, 32'hD,  64'h100C, 1,  1, 32'hD, 64'h100C, 1);
        vt[6]  = mk(0, 0, 1, 32'hE,  64'h1010, 1,  1, 32'hE, 64'h1010, 1);
        vt[7]  = mk(0, 0, 1, 32'hF,  64'h1014, 1,  1, 32'hF, 64'h1014, 1);
        vt[8]  = mk(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,   64'h0,    1);
        // backpressure: two held, third waits, then in-order drain
        vt[9]  = mk(0, 0, 1, 32'h21, 64'h2000, 0,  1, 32'h21, 64'h2000, 1);
        vt[10] = mk(0, 0, 1, 32'h22, 64'h2004, 0,  1, 32'h21, 64'h2000, 0);
        vt[11] = mk(0, 0, 1, 32'h23, 64'h2008, 0,  1, 32'h21, 64'h2000, 0);
        vt[12] = mk(0, 0, 1, 32'h23, 64'h2008, 1,  1, 32'h22, 64'h2004, 1);
        vt[13] = mk(0, 0, 1, 32'h23, 64'h2008, 1,  1, 32'h23, 64'h2008, 1);
        vt[14] = mk(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,    64'h0,    1);
        // flush while FULL with a pending input
        vt[15] = mk(0, 0, 1, 32'h31, 64'h3000, 0,  1, 32'h31, 64'h3000, 1);
        vt[16] = mk(0, 0, 1, 32'h32, 64'h3004, 0,  1, 32'h31, 64'h3000, 0);
        vt[17] = mk(0, 1, 1, 32'h33, 64'h3008, 0,  0, NOP,    64'h0,    1);
        vt[18] = mk(0, 0, 0, 32'h0,  64'h0,    0,  0, NOP,    64'h0,    1);
        // flush while BUSY discards an input even though in_ready = 1
        vt[19] = mk(0, 0, 1, 32'h41, 64'h4000, 1,  1, 32'h41, 64'h4000, 1);
        vt[20] = mk(0, 1, 1, 32'h42, 64'h4004, 1,  0, NOP,    64'h0,    1);
        vt[21] = mk(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,    64'h0,    1);
        // rst + flush while FULL and stalled
        vt[22] = mk(0, 0, 1, 32'h51, 64'h5000, 0,  1, 32'h51, 64'h5000, 1);
        vt[23] = mk(0, 0, 1, 32'h52, 64'h5004, 0,  1, 32'h51, 64'h5000, 0);
        vt[24] = mk(1, 1, 1, 32'h53, 64'h5008, 0,  0, NOP,    64'h0,    1);
        vt[25] = mk(0, 0, 0, 32'h0,  64'h0,    0,  0, NOP,    64'h0,    1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            rst       = vt[i].rst;
            flush     = vt[i].flush;
            in_valid  = vt[i].iv;
            in_inst   = vt[i].inst;
            in_pc     = vt[i].pc;
            out_ready = vt[i].ordy;
            step();
            check_outs($sformatf("vec[%0d]", i), vt[i].e_ov, vt[i].e_inst, vt[i].e_pc, vt[i].e_ir);
        end

`ifdef PIPE_PERF_CNT_EN
        // counters: cleared by rst even with flush asserted
        rst = 1'b1; flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        check_cnt("rst_stall_cnt", stall_cnt, 4'd0);
        check_cnt("rst_flush_cnt", flush_cnt, 4'd0);
        rst = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_inst = 32'h61; in_pc = 64'h6000;
        step();
        in_valid = 1'b0;
        repeat (14) step();
        check_cnt("stall_cnt_14", stall_cnt, 4'd14);
        repeat (6) step();
        check_cnt("stall_cnt_sat", stall_cnt, 4'd15);
        for (int k = 0; k < 3; k++) begin
            flush = 1'b1; step();
            flush = 1'b0; step();
        end
        check_cnt("flush_cnt_3", flush_cnt, 4'd3);
        check_cnt("stall_kept_by_flush", stall_cnt, 4'd15);
`endif

        // randomized run against a two-deep FIFO model
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic r, f, iv, ordy, m_ov, m_ir;
            ent_t e;
            r    = (c == 0) || ($urandom_range(0, 99) == 0);
            f    = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 9) < 7);
            e.inst = $urandom;
            e.pc   = {$urandom, $urandom};

            m_ov = (mq.size() > 0);
            m_ir = (mq.size() < 2);
            if (r || f) begin
                mq.delete();
            end else begin
                if (m_ov && ordy) void'(mq.pop_front());
                if (iv && m_ir)   mq.push_back(e);
            end

            rst = r; flush = f; in_valid = iv; out_ready = ordy;
            in_inst = e.inst; in_pc = e.pc;
            step();
            if (mq.size() > 0)
                check_outs($sformatf("rand[%0d]", c), 1'b1, mq[0].inst, mq[0].pc, mq.size() < 2);
            else
                check_outs($sformatf("rand[%0d]", c), 1'b0, NOP, 64'h0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
